// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped fetch-stage BTB with 2-bit direction counters;
//               zero-latency lookup, one-update-per-cycle write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        predicted_taken,
    output logic [31:0] predicted_pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        update_is_jump,
    input  logic        flush
);

    localparam int c_TAG_W = 32 - IDX_W - 2;

    logic               r_valid  [ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IDX_W-1:0]   w_fetch_idx;
    logic [c_TAG_W-1:0] w_fetch_tag;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [c_TAG_W-1:0] w_upd_tag;
    logic               w_fetch_hit;
    logic               w_upd_hit;
    logic [1:0]         w_ctr_next;
    logic               w_unused_bits;

    assign w_fetch_idx   = fetch_pc[IDX_W+1:2];
    assign w_fetch_tag   = fetch_pc[31:IDX_W+2];
    assign w_upd_idx     = update_pc[IDX_W+1:2];
    assign w_upd_tag     = update_pc[31:IDX_W+2];
    assign w_unused_bits = &{fetch_pc[1:0], update_pc[1:0]};

    // Lookup reads the registered table only, so same-cycle updates are not bypassed.
    always_comb begin
        w_fetch_hit     = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
        pred_valid      = w_fetch_hit;
        predicted_taken = w_fetch_hit && r_ctr[w_fetch_idx][1];
        predicted_pc    = predicted_taken ? r_target[w_fetch_idx] : fetch_pc + 32'h4;
    end

    always_comb begin
        w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_ctr_next = r_ctr[w_upd_idx];
        if (!w_upd_hit) begin
            if (update_is_jump)    w_ctr_next = 2'b11;
            else if (update_taken) w_ctr_next = 2'b10;
            else                   w_ctr_next = 2'b01;
        end else if (update_is_jump) begin
            w_ctr_next = 2'b11;
        end else if (update_taken) begin
            if (r_ctr[w_upd_idx] != 2'b11) w_ctr_next = r_ctr[w_upd_idx] + 2'b01;
        end else begin
            if (r_ctr[w_upd_idx] != 2'b00) w_ctr_next = r_ctr[w_upd_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b00;
            end
        end else if (flush) begin
            // A coincident update is intentionally dropped.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (update_en) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_tag[w_upd_idx]   <= w_upd_tag;
            r_ctr[w_upd_idx]   <= w_ctr_next;
            if (!w_upd_hit || update_taken) begin
                r_target[w_upd_idx] <= update_target;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Scoreboard bench for branch_target_buffer (ENTRIES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    localparam int c_ENTRIES = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        predicted_taken;
    logic [31:0] predicted_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        update_is_jump;
    logic        flush;

    branch_target_buffer #(.ENTRIES(c_ENTRIES)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_pc        (fetch_pc),
        .pred_valid      (pred_valid),
        .predicted_taken (predicted_taken),
        .predicted_pc    (predicted_pc),
        .update_en       (update_en),
        .update_pc       (update_pc),
        .update_target   (update_target),
        .update_taken    (update_taken),
        .update_is_jump  (update_is_jump),
        .flush           (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table: {valid, tag, target, ctr} per index.
    logic        m_valid  [c_ENTRIES];
    logic [25:0] m_tag    [c_ENTRIES];
    logic [31:0] m_target [c_ENTRIES];
    logic [1:0]  m_ctr    [c_ENTRIES];

    logic [33:0] sb_q [$];
    int          n_vec;
    int          n_err;

    task automatic check_vec(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got valid=%0b taken=%0b pc=%08h, want valid=%0b taken=%0b pc=%08h",
                     tag, obs[33], obs[32], obs[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [33:0] model_predict(input logic [31:0] pc);
        logic [3:0] idx;
        logic       hit;
        logic       tkn;
        idx = pc[5:2];
        hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        tkn = hit && m_ctr[idx][1];
        return {hit, tkn, tkn ? m_target[idx] : pc + 32'h4};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 2'b00;
        end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tk, input logic jmp);
        logic [3:0] idx;
        idx = pc[5:2];
        if (m_valid[idx] && m_tag[idx] == pc[31:6]) begin
            if (jmp)                           m_ctr[idx] = 2'b11;
            else if (tk && m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
            else if (!tk && m_ctr[idx] != 2'b00) m_ctr[idx] = m_ctr[idx] - 2'b01;
            if (tk) m_target[idx] = tgt;
        end else begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = pc[31:6];
            m_target[idx] = tgt;
            m_ctr[idx]    = jmp ? 2'b11 : (tk ? 2'b10 : 2'b01);
        end
    endtask

    // One cycle: drive at negedge, push expected, compare away from the edge,
    // then advance the model to reflect the coming rising edge.
    task automatic step(input string tag, input logic [31:0] fpc, input logic ue,
                        input logic [31:0] upc, input logic [31:0] utgt,
                        input logic ut, input logic uj, input logic fl);
        logic [33:0] exp;
        @(negedge clk);
        fetch_pc       = fpc;
        update_en      = ue;
        update_pc      = upc;
        update_target  = utgt;
        update_taken   = ut;
        update_is_jump = uj;
        flush          = fl;
        sb_q.push_back(model_predict(fpc));
        #1;
        exp = sb_q.pop_front();
        check_vec(tag, {pred_valid, predicted_taken, predicted_pc}, exp);
        if (fl)      model_reset_valid();
        else if (ue) model_update(upc, utgt, ut, uj);
    endtask

    task automatic model_reset_valid();
        for (int i = 0; i < c_ENTRIES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] fpc);
        step(tag, fpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic upd(input string tag, input logic [31:0] fpc, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic ut, input logic uj);
        step(tag, fpc, 1'b1, upc, utgt, ut, uj, 1'b0);
    endtask

    // Literal expectation for the current (still-held) lookup.
    task automatic expect_now(input string tag, input logic v, input logic t, input logic [31:0] pc);
        check_vec(tag, {pred_valid, predicted_taken, predicted_pc}, {v, t, pc});
    endtask

    logic [31:0] pc_pool [8];

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        fetch_pc = 32'h100; update_en = 1'b0; update_pc = '0; update_target = '0;
        update_taken = 1'b0; update_is_jump = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        look("reset_miss", 32'h100);          expect_now("reset_lit", 1'b0, 1'b0, 32'h104);

        upd("alloc_taken", 32'h100, 32'h100, 32'h80, 1'b1, 1'b0);
        look("hit_taken", 32'h100);           expect_now("hit_lit", 1'b1, 1'b1, 32'h80);
        upd("nt1", 32'h100, 32'h100, 32'hDEAD0, 1'b0, 1'b0);
        upd("nt2", 32'h100, 32'h100, 32'hDEAD0, 1'b0, 1'b0);
        look("ctr00", 32'h100);               expect_now("ctr00_lit", 1'b1, 1'b0, 32'h104);
        for (int i = 0; i < 4; i++) upd("tk_sat", 32'h100, 32'h100, 32'h80, 1'b1, 1'b0);
        look("sat11", 32'h100);               expect_now("sat11_lit", 1'b1, 1'b1, 32'h80);
        upd("from11", 32'h100, 32'h100, 32'h0, 1'b0, 1'b0);
        look("ctr10", 32'h100);               expect_now("ctr10_lit", 1'b1, 1'b1, 32'h80);

        upd("alias_alloc", 32'h100, 32'h140, 32'h999, 1'b0, 1'b0);
        look("alias_old", 32'h100);           expect_now("alias_old_lit", 1'b0, 1'b0, 32'h104);
        look("alias_new", 32'h140);           expect_now("alias_new_lit", 1'b1, 1'b0, 32'h144);

        upd("jump_alloc", 32'h200, 32'h200, 32'h3000, 1'b1, 1'b1);
        look("jump_hit", 32'h200);            expect_now("jump_lit", 1'b1, 1'b1, 32'h3000);
        upd("jump_nt", 32'h200, 32'h200, 32'h7777, 1'b0, 1'b0);
        look("jump_ctr10", 32'h200);          expect_now("jump_ctr10_lit", 1'b1, 1'b1, 32'h3000);
        upd("jump_nt2", 32'h200, 32'h200, 32'h7777, 1'b0, 1'b0);
        look("jump_ctr01", 32'h200);          expect_now("jump_ctr01_lit", 1'b1, 1'b0, 32'h204);

        upd("collide", 32'h200, 32'h200, 32'h4000, 1'b1, 1'b0);
        expect_now("collide_old", 1'b1, 1'b0, 32'h204);
        look("collide_next", 32'h200);        expect_now("collide_new", 1'b1, 1'b1, 32'h4000);

        look("wrap_miss", 32'hFFFF_FFFC);     expect_now("wrap_miss_lit", 1'b0, 1'b0, 32'h0);
        upd("wrap_alloc", 32'h0, 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b0);
        look("wrap_hit", 32'hFFFF_FFFC);      expect_now("wrap_hit_lit", 1'b1, 1'b0, 32'h0);

        step("flush_upd", 32'h200, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
        expect_now("flush_preview", 1'b1, 1'b1, 32'h4000);
        look("flushed_100", 32'h100);         expect_now("flushed_100_lit", 1'b0, 1'b0, 32'h104);
        look("flushed_200", 32'h200);         expect_now("flushed_200_lit", 1'b0, 1'b0, 32'h204);
        look("flushed_wrap", 32'hFFFF_FFFC);  expect_now("flushed_wrap_lit", 1'b0, 1'b0, 32'h0);

        upd("pre_rst", 32'h300, 32'h300, 32'h500, 1'b1, 1'b0);
        look("pre_rst_hit", 32'h300);         expect_now("pre_rst_lit", 1'b1, 1'b1, 32'h500);
        #1 rst_n = 1'b0;
        #1 expect_now("async_rst", 1'b0, 1'b0, 32'h304);
        model_reset();
        @(posedge clk);
        #1 expect_now("rst_held", 1'b0, 1'b0, 32'h304);
        @(negedge clk);
        rst_n = 1'b1;
        look("post_rst", 32'h300);            expect_now("post_rst_lit", 1'b0, 1'b0, 32'h304);

        pc_pool[0] = 32'h100; pc_pool[1] = 32'h140; pc_pool[2] = 32'h200; pc_pool[3] = 32'h104;
        pc_pool[4] = 32'h13C; pc_pool[5] = 32'hFFFF_FFFC; pc_pool[6] = 32'h1000_0008; pc_pool[7] = 32'h8;
        for (int i = 0; i < 300; i++) begin
            step("random",
                 pc_pool[$urandom_range(0, 7)],
                 1'($urandom_range(0, 3) != 0),
                 pc_pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
                 32'($urandom) & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with 2-bit saturating direction counters, located in the fetch stage. Each cycle it looks up the fetch PC combinationally and drives the prediction (valid, taken, next PC) that travels down the pipe with the instruction. One cycle later the execute stage's branch resolution writes the resolved outcome back into the table.

Parameters:
ENTRIES, 16, number of table entries; power of two, minimum 2.
IDX_W, $clog2(ENTRIES), index width. Derived; do not override.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
fetch_pc  input  32  PC being fetched this cycle.
pred_valid  output  1  fetch_pc hit a valid entry.
predicted_taken  output  1  predicted direction.
predicted_pc  output  32  predicted next PC.
update_en  input  1  resolved branch or jump from execute (execute's update_btb).
update_pc  input  32  PC of the resolved instruction.
update_target  input  32  resolved target address (execute's jump_addr).
update_taken  input  1  resolved direction; 1 for all jumps.
update_is_jump  input  1  instruction is JAL/JALR.
flush  input  1  synchronous invalidate of every entry.

Behaviour:
- Addressing: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid(1), tag, target(32), ctr(2).
- Reset (async, rst_n=0): all valid=0, ctr=2'b00; target and tag cleared to 0.
- Lookup is purely combinational with zero latency.
  - hit = valid[idx] && tag[idx]==fetch_tag.
  - pred_valid = hit.
  - predicted_taken = hit && ctr[idx][1].
  - predicted_pc = predicted_taken ? target[idx] : fetch_pc+32'h4 (modulo 2^32; 0xFFFFFFFC+4 wraps to 0).
  - With no valid entries: pred_valid=0, predicted_taken=0, predicted_pc=fetch_pc+4.
- Update, on a rising edge with update_en=1 and flush=0, at entry u = update index:
  - Tag match with valid entry:
    - ctr increments saturating at 2'b11 if update_taken, decrements saturating at 2'b00 otherwise.
    - target <= update_target only when update_taken=1.
  - Miss (invalid or tag mismatch): allocate and overwrite.
    - valid <= 1, tag <= update tag, target <= update_target.
    - ctr <= 2'b11 if update_is_jump; 2'b10 if update_taken; 2'b01 otherwise.
  - update_is_jump with a hit forces ctr <= 2'b11.
- Read/write collision: when lookup and update hit the same index in the same cycle, the lookup returns pre-update contents. New contents become visible the next cycle. No bypass.
- flush=1: all valid <= 0 on that edge. Flush wins over a simultaneous update_en, which is dropped. Lookup in the flush cycle still uses pre-flush contents.
- Reset asserted mid-operation clears state immediately, regardless of clk. Outputs follow the empty-table values combinationally.
- No stall input. Updates are never back-pressured. At most one update per cycle.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_valid=0, predicted_taken=0, predicted_pc=0x104.
- Update pc=0x100, target=0x80, taken=1, is_jump=0. Next cycle fetch 0x100 -> pred_valid=1, taken=1 (ctr=10), predicted_pc=0x80. Two not-taken updates -> ctr=00, predicted_pc=0x104. Four taken updates -> ctr saturates at 11.
- Alias, ENTRIES=16: entry exists for 0x100. Update pc=0x140 (same index 0, different tag), taken=0 -> fetch 0x100 gives pred_valid=0. Fetch 0x140 gives pred_valid=1, taken=0 (ctr=01), predicted_pc=0x144.
- Jump: update pc=0x200, target=0x3000, is_jump=1, taken=1 -> ctr=11. One not-taken branch update at 0x200 -> ctr=10, still predicts 0x3000.
- Collision: fetch_pc=0x100 and update at 0x100 in the same cycle -> old prediction that cycle, new prediction the following cycle.
- Flush together with update_en, plus async reset asserted between clock edges -> all lookups miss afterwards. The flushed update is not written.
- Wrap: entry at 0xFFFFFFFC, not taken -> predicted_pc=0x00000000.
